// File: rtl/bus_timer_pkg.sv
// Shared constants for bus_timer: register offsets, CTRL bit positions and FSM encoding.
// Optional auto-reload support is selected by the BUS_TIMER_AUTORELOAD_EN macro in bus_timer.sv.
package bus_timer_pkg;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PRESET = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;
    localparam logic [1:0] TMR_RSVD   = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

endpackage

// File: rtl/bus_timer_byte_merge.sv
// byte_merge: combinational byte-lane merge of a store into an existing word.
// Bit i takes the new value when the byte lane holding it (i/8) is enabled.
module byte_merge #(
    parameter int W  = 32,
    parameter int NB = (W + 7) / 8
) (
    input  logic [W-1:0]  old_i,
    input  logic [W-1:0]  new_i,
    input  logic [NB-1:0] byteen_i,
    output logic [W-1:0]  merged_o
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign merged_o[i] = byteen_i[i / 8] ? new_i[i] : old_i[i];
    end

endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped countdown timer on the CPU data-memory port, with interrupt on expiry.
// Define BUS_TIMER_AUTORELOAD_EN to store CTRL.MODE and enable auto-reload (MODE 2'b01).
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [1:0]  dbg_state_o
);

    // Bus access is single-cycle with no backpressure: a store is taken on every edge
    // where hit & |m_data_byteen, and loads are answered combinationally in the same cycle.
    logic        wr_en, wr_ctrl, wr_preset;
    logic [1:0]  state_q, state_d;
    logic        en_q, en_d, im_q, im_d;
    logic [1:0]  mode_q;
    logic        auto_reload;
    logic [31:0] preset_q, preset_d, preset_new;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d, irq_q;
    logic [3:0]  ctrl_rd, ctrl_new;
    logic        unused_addr;

    assign hit         = (m_data_addr[31:4] == BASE_ADDR[31:4]);
    assign wr_en       = hit & (|m_data_byteen);
    assign wr_ctrl     = wr_en && (m_data_addr[3:2] == TMR_CTRL);
    assign wr_preset   = wr_en && (m_data_addr[3:2] == TMR_PRESET);
    assign unused_addr = ^m_data_addr[1:0];
    assign irq         = irq_q;
    assign dbg_state_o = state_q;

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_EN] = en_q;
        ctrl_rd[CTRL_MODE_LO +: 2] = mode_q;
        ctrl_rd[CTRL_IM] = im_q;
    end

    byte_merge #(.W(4)) u_ctrl_merge (
        .old_i    (ctrl_rd),
        .new_i    (m_data_wdata[3:0]),
        .byteen_i (m_data_byteen[0:0]),
        .merged_o (ctrl_new)
    );

    byte_merge #(.W(32)) u_preset_merge (
        .old_i    (preset_q),
        .new_i    (m_data_wdata),
        .byteen_i (m_data_byteen),
        .merged_o (preset_new)
    );

`ifdef BUS_TIMER_AUTORELOAD_EN
    logic [1:0] mode_d;
    assign mode_d      = wr_ctrl ? ctrl_new[CTRL_MODE_LO +: 2] : mode_q;
    assign auto_reload = (mode_q == 2'b01);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= 2'b00;
        end else begin
            mode_q <= mode_d;
        end
    end
`else
    logic unused_mode;
    assign mode_q      = 2'b00;
    assign auto_reload = 1'b0;
    assign unused_mode = ^ctrl_new[CTRL_MODE_LO +: 2];
`endif

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (m_data_addr[3:2])
                TMR_CTRL:   rdata = {28'd0, ctrl_rd};
                TMR_PRESET: rdata = preset_q;
                TMR_COUNT:  rdata = count_q;
                default:    rdata = '0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        im_d      = im_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        if (wr_preset) begin
            preset_d = preset_new;
        end
        if (wr_ctrl) begin
            en_d = ctrl_new[CTRL_EN];
            im_d = ctrl_new[CTRL_IM];
        end
        if (!auto_reload && (wr_ctrl || wr_preset)) begin
            pending_d = 1'b0;
        end

        // A PRESET of 0 falls into the expiry branch on the first CNT cycle, same as 1.
        case (state_q)
            ST_IDLE: begin
                if (en_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d   = '0;
                    pending_d = 1'b1;
                    state_d   = ST_INT;
                end
            end
            ST_INT: begin
                if (auto_reload) begin
                    pending_d = 1'b0;
                    state_d   = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    if (!wr_ctrl) en_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            im_q      <= 1'b0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            im_q      <= im_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            irq_q     <= pending_d & im_d;
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: timeline-based reference model feeding an expected queue,
// a negedge monitor that compares every cycle, directed scenarios and a random phase.
module tb_bus_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;
`ifdef BUS_TIMER_AUTORELOAD_EN
    localparam bit AR_BUILD = 1'b1;
`else
    localparam bit AR_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        hit, irq;
    logic [31:0] rdata;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    bus_timer #(.BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .m_data_addr   (addr),
        .m_data_wdata  (wdata),
        .m_data_byteen (be),
        .hit           (hit),
        .rdata         (rdata),
        .irq           (irq),
        .dbg_state_o   (dbg_state)
    );

    int checks = 0;
    int failures = 0;
    logic [33:0] exp_q[$];

    // Reference model: the running count is derived from the edge on which it was loaded.
    localparam int PH_IDLE = 0, PH_ARMED = 1, PH_RUN = 2, PH_EXPIRED = 3;
    int          ph;
    bit          m_en, m_im, m_pending, m_irq;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_frozen, m_p;
    longint      edge_no, m_load_edge;

    function automatic logic [31:0] lane_merge(logic [31:0] o, logic [31:0] n, logic [3:0] b);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_count();
        if (ph == PH_RUN) return m_p - 32'(edge_no - m_load_edge);
        return m_frozen;
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return '0;
        case (a[3:2])
            2'd0:    return {28'd0, m_im, (AR_BUILD ? m_mode : 2'b00), m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count();
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        ph = PH_IDLE; m_en = 0; m_im = 0; m_pending = 0; m_irq = 0; m_mode = 2'b00;
        m_preset = '0; m_frozen = '0; m_p = '0; m_load_edge = 0;
    endtask

    task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        bit wc, wp, ar, n_en, n_im, n_pend;
        logic [1:0] n_mode;
        logic [31:0] n_preset, cur;
        longint lim;
        cur = m_count();
        edge_no++;
        wc = (a[31:4] == BASE[31:4]) && (b != 4'd0) && (a[3:2] == 2'd0);
        wp = (a[31:4] == BASE[31:4]) && (b != 4'd0) && (a[3:2] == 2'd1);
        ar = AR_BUILD && (m_mode == 2'b01);
        n_en = m_en; n_im = m_im; n_mode = m_mode; n_preset = m_preset; n_pend = m_pending;
        if (wc && b[0]) begin
            n_en = d[0]; n_im = d[3];
            if (AR_BUILD) n_mode = d[2:1];
        end
        if (wp) n_preset = lane_merge(m_preset, d, b);
        if (!ar && (wc || wp)) n_pend = 0;
        lim = (m_p == 0) ? 1 : longint'(m_p);
        case (ph)
            PH_IDLE:  if (m_en) ph = PH_ARMED;
            PH_ARMED: begin m_load_edge = edge_no; m_p = m_preset; ph = PH_RUN; end
            PH_RUN: begin
                if (!m_en) begin
                    m_frozen = cur; ph = PH_IDLE;
                end else if (edge_no == m_load_edge + lim) begin
                    m_frozen = '0; n_pend = 1; ph = PH_EXPIRED;
                end
            end
            default: begin
                if (ar) begin n_pend = 0; ph = PH_ARMED; end
                else begin ph = PH_IDLE; if (!wc) n_en = 0; end
            end
        endcase
        m_en = n_en; m_im = n_im; m_mode = n_mode; m_preset = n_preset; m_pending = n_pend;
        m_irq = n_pend & n_im;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [33:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("bus_hit", 32'(hit), 32'(e[33]));
            chk("bus_irq", 32'(irq), 32'(e[32]));
            chk("bus_rdata", rdata, e[31:0]);
        end
    end

    logic [31:0] o_rd;
    logic        o_irq, o_hit;

    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b;
        exp_q.push_back({(a[31:4] == BASE[31:4]), m_irq, m_read(a)});
        @(negedge clk);
        #1;
        o_rd = rdata; o_irq = irq; o_hit = hit;
        @(posedge clk);
        model_edge(a, d, b);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] b);
        cycle(BASE + off, d, b);
    endtask

    task automatic rd(input logic [31:0] off);
        cycle(BASE + off, 32'd0, 4'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) rd(32'd8);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int rises, highs, first, last;
        bit prev;
        int r;
        logic [31:0] a;
        model_reset();
        edge_no = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        rd(0);  chk("reset_ctrl", o_rd, 0); chk("reset_irq", 32'(o_irq), 0);
        rd(4);  chk("reset_preset", o_rd, 0);
        rd(8);  chk("reset_count", o_rd, 0);

        // One-shot, PRESET = 5
        wr(4, 32'd5, 4'hF);
        wr(0, 32'h9, 4'hF);
        for (int k = 0; k <= 9; k++) begin
            rd(8);
            chk("os_count", o_rd, (k < 2) ? 32'd0 : (k <= 7 ? 32'(7 - k) : 32'd0));
            chk("os_irq", 32'(o_irq), (k >= 7) ? 32'd1 : 32'd0);
        end
        rd(0); chk("os_en_cleared", o_rd, 32'h8);

        // Byte lanes and read-only COUNT
        wr(4, 32'h1122_3344, 4'hF);
        wr(4, 32'hAABB_CCDD, 4'b0101);
        rd(4); chk("lane_preset", o_rd, 32'h11BB_33DD);
        wr(8, 32'hFFFF_FFFF, 4'hF);
        rd(8); chk("count_ro", o_rd, 0);

        // Auto-reload (single expiry when not built in)
        wr(4, 32'd3, 4'hF);
        wr(0, 32'hB, 4'hF);
        rises = 0; highs = 0; first = -1; last = -1; prev = 0;
        for (int k = 0; k <= 21; k++) begin
            rd(8);
            if (o_irq) highs++;
            if (o_irq && !prev) begin
                rises++;
                if (first < 0) first = k;
                last = k;
            end
            prev = o_irq;
        end
        chk("ar_first_irq", 32'(first), 32'd5);
`ifdef BUS_TIMER_AUTORELOAD_EN
        chk("ar_rises", 32'(rises), 32'd4);
        chk("ar_pulse_cycles", 32'(highs), 32'd4);
        chk("ar_last_irq", 32'(last), 32'd20);
        rd(0); chk("ar_ctrl", o_rd, 32'hB);
`else
        chk("os_rises", 32'(rises), 32'd1);
        chk("os_held_cycles", 32'(highs), 32'd17);
        rd(0); chk("os_ctrl_mode0", o_rd, 32'h8);
`endif
        wr(0, 32'h0, 4'hF);
        idle(4);

        // Pause and re-enable
        wr(4, 32'd20, 4'hF);
        wr(0, 32'h1, 4'hF);
        for (int k = 0; k <= 10; k++) begin
            rd(8);
            if (k == 2) chk("pause_load", o_rd, 32'd20);
        end
        wr(0, 32'h0, 4'hF);
        for (int j = 0; j < 5; j++) begin
            rd(8);
            chk("pause_frozen", o_rd, 32'd10);
            chk("pause_irq", 32'(o_irq), 0);
        end
        wr(0, 32'h1, 4'hF);
        for (int k = 0; k <= 3; k++) begin
            rd(8);
            if (k == 2) chk("resume_reload", o_rd, 32'd20);
            if (k == 3) chk("resume_dec", o_rd, 32'd19);
        end
        wr(0, 32'h0, 4'hF);
        idle(3);

        // CPU write to CTRL on the INT edge
        wr(4, 32'd2, 4'hF);
        wr(0, 32'h9, 4'hF);
        for (int k = 0; k <= 9; k++) begin
            if (k == 4) begin
                wr(0, 32'h9, 4'hF);
                chk("coll_irq_int", 32'(o_irq), 1);
            end else if (k == 5) begin
                rd(0);
                chk("coll_en_kept", o_rd, 32'h9);
                chk("coll_pending_clr", 32'(o_irq), 0);
            end else begin
                rd(8);
                if (k == 7) chk("coll_reload", o_rd, 32'd2);
                if (k == 8) chk("coll_irq_lo", 32'(o_irq), 0);
                if (k == 9) chk("coll_irq_again", 32'(o_irq), 1);
            end
        end
        wr(0, 32'h0, 4'hF);
        idle(2);

        // PRESET = 0 times like PRESET = 1
        wr(4, 32'd0, 4'hF);
        wr(0, 32'h9, 4'hF);
        for (int k = 0; k <= 4; k++) begin
            rd(8);
            if (k == 2) chk("p0_irq_lo", 32'(o_irq), 0);
            if (k == 3) chk("p0_irq_hi", 32'(o_irq), 1);
        end
        wr(0, 32'h0, 4'hF);
        idle(2);

        // Asynchronous reset mid-count
        wr(4, 32'd50, 4'hF);
        wr(0, 32'h9, 4'hF);
        repeat (5) rd(8);
        addr = BASE + 32'd8; wdata = '0; be = '0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_async_rdata", rdata, 0);
        chk("rst_async_irq", 32'(irq), 0);
        model_reset();
        #1 reset_n = 1'b1;
        @(posedge clk);
        model_edge(BASE + 32'd8, 32'd0, 4'd0);
        #1;
        rd(0); chk("rst_ctrl", o_rd, 0);
        rd(4); chk("rst_preset", o_rd, 0);

        // Address decode
        wr(4, 32'h0000_1234, 4'hF);
        wr(12, 32'hFFFF_FFFF, 4'hF);
        rd(12); chk("rsvd_zero", o_rd, 0);
        rd(16); chk("out_hit", 32'(o_hit), 0); chk("out_rdata", o_rd, 0);
        wr(20, 32'hDEAD_BEEF, 4'hF);
        cycle(BASE + 32'h100, 32'hFFFF_FFFF, 4'hF);
        cycle(32'h0, 32'hFFFF_FFFF, 4'hF);
        rd(4); chk("out_preset_kept", o_rd, 32'h0000_1234);
        rd(0); chk("out_ctrl_kept", o_rd, 0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                rd(32'(4 * $urandom_range(0, 3)));
            end else if (r == 6) begin
                wr(0, ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end else if (r == 7) begin
                wr(4, 32'($urandom_range(0, 12)), 4'($urandom_range(0, 15)));
            end else if (r == 8) begin
                wr(32'(8 + 4 * $urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)));
            end else begin
                a = ($urandom_range(0, 1) == 0) ? BASE + 32'h10 + 32'(4 * $urandom_range(0, 3)) : $urandom;
                cycle(a, $urandom, 4'($urandom_range(0, 15)));
            end
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
